fetch_stage: RTL

- IF stage of the RV32I pipeline: owns the PC, issues instruction-memory requests over a req/gnt/rvalid handshake, and drives the IF/ID pipeline register consumed by decode.
- Directly upstream of decode and the hazard unit. Obeys the hazard unit's PC/IF-ID stall outputs and the ID-stage branch/JALR redirect (flush).
- Has one outstanding request and a 1-entry hold buffer, so a response that lands during a stall is never lost.

---
 rtl/fetch_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem req/gnt/rvalid
// handshake and drives the IF/ID register, with a 1-entry hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_pc,
    input  logic        i_stall_if_id,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc_plus4,
    output logic [31:0] o_if_id_inst
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    logic        hold_valid;
    logic        discard;

    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_inst;

    logic        req;
    logic        fire;
    logic        resp;
    logic        take;
    logic        unused_lsb;

    assign req  = (state == REQ) && !i_stall_pc && !hold_valid;
    assign fire = req && i_imem_gnt;
    assign resp = (state == WAIT) && i_imem_rvalid;
    assign take = resp && !discard;

    assign unused_lsb = ^i_redirect_pc[1:0];

    assign o_imem_req       = req;
    assign o_imem_addr      = pc;
    assign o_if_id_valid    = if_id_valid;
    assign o_if_id_pc       = if_id_pc;
    assign o_if_id_pc_plus4 = if_id_pc_plus4;
    assign o_if_id_inst     = if_id_inst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            pc             <= RESET_ADDR;
            fetch_pc       <= RESET_ADDR;
            hold_pc        <= 32'd0;
            hold_inst      <= NOP_INST;
            hold_valid     <= 1'b0;
            discard        <= 1'b0;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'd0;
            if_id_pc_plus4 <= 32'd4;
            if_id_inst     <= NOP_INST;
        end else if (i_redirect) begin
            pc          <= {i_redirect_pc[31:2], 2'b00};
            hold_valid  <= 1'b0;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            // a response still owed by memory must be swallowed on arrival
            if (fire || (state == WAIT && !i_imem_rvalid)) begin
                discard <= 1'b1;
                state   <= WAIT;
            end else begin
                discard <= 1'b0;
                state   <= REQ;
            end
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (fire) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase

            if (resp) begin
                discard <= 1'b0;
            end

            if (take && i_stall_if_id) begin
                hold_pc    <= fetch_pc;
                hold_inst  <= i_imem_rdata;
                hold_valid <= 1'b1;
            end

            // buffered word is older than any new response
            if (!i_stall_if_id) begin
                if (hold_valid) begin
                    if_id_valid    <= 1'b1;
                    if_id_pc       <= hold_pc;
                    if_id_pc_plus4 <= hold_pc + 32'd4;
                    if_id_inst     <= hold_inst;
                    hold_valid     <= 1'b0;
                end else if (take) begin
                    if_id_valid    <= 1'b1;
                    if_id_pc       <= fetch_pc;
                    if_id_pc_plus4 <= fetch_pc + 32'd4;
                    if_id_inst     <= i_imem_rdata;
                end else begin
                    if_id_valid <= 1'b0;
                    if_id_inst  <= NOP_INST;
                end
            end
        end
    end

endmodule
